// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash stream reader.
// Optional feature macro: SPI_FLASH_FAST_READ_EN (fast read 0x0B with 8 dummy clocks).
`timescale 1ns/1ps
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_HOLD,
        ST_FINISH
    } state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    // Longest possible header: opcode + 24-bit address + dummy byte
    localparam int unsigned HDR_MAX = 40;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int unsigned HDR_BITS   = 40;
    localparam logic [7:0]  CMD_OPCODE = CMD_FAST_READ;
`else
    localparam int unsigned HDR_BITS   = 32;
    localparam logic [7:0]  CMD_OPCODE = CMD_READ;
`endif

    // Header image shifted out MSB first; the trailing dummy byte is only sent in fast read
    function automatic logic [HDR_MAX-1:0] build_header(input logic [7:0] op,
                                                        input logic [23:0] addr);
        return {op, addr, 8'h00};
    endfunction

endpackage

// File: rtl/spi_flash_stream_clk_gen.sv
// spi_clk_gen: SPI clock divider producing one-cycle rise/fall strobes.
// Ports: clk, rst_n (async active-low), i_en (shifting active; low clears to phase 0),
//        o_rise_c / o_fall_c (combinational strobes, one clk cycle wide).
`timescale 1ns/1ps
module spi_clk_gen
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_tick;

    assign w_tick   = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
    // Phase 0 means the next strobe is a rising edge
    assign o_rise_c = w_tick && !r_phase;
    assign o_fall_c = w_tick &&  r_phase;

    // Half-period counter and edge phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_flash_stream.sv
// spi_flash_stream: streams a byte range from SPI flash (mode 0) onto a valid/ready byte port.
// Ports: clk, rst_n (async active-low); start/start_addr/length request; abort;
//        busy/done status; out_data/out_valid/out_ready stream; sck/mosi/miso/cs_n SPI pins.
// Optional feature macro: SPI_FLASH_FAST_READ_EN selects opcode 0x0B plus 8 dummy clocks.
`timescale 1ns/1ps
module spi_flash_stream
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int unsigned GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

    state_t             r_state;
    logic [LEN_W-1:0]   r_cnt;
    logic [HDR_MAX-1:0] r_tx;
    logic [5:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_pend;
    logic               r_last;
    logic               r_abort;
    logic [GAP_W-1:0]   r_gap;

    logic               w_en;
    logic               w_rise;
    logic               w_fall;
    logic               w_free;
    logic               w_move;
    logic [HDR_MAX-1:0] w_hdr;

    assign w_en   = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                    (r_state == ST_DUMMY) || (r_state == ST_DATA);
    assign w_free = !out_valid || out_ready;
    // A completed byte leaves the shift register as soon as the output slot frees
    assign w_move = r_pend && w_free;
    assign w_hdr  = build_header(CMD_OPCODE, 24'(start_addr));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_en),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // Transfer FSM with registered SPI and stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tx      <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_pend    <= 1'b0;
            r_last    <= 1'b0;
            r_abort   <= 1'b0;
            r_gap     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
        end else begin
            done <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_move) begin
                out_data  <= r_shift;
                out_valid <= 1'b1;
                r_pend    <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            r_state <= ST_CMD;
                            busy    <= 1'b1;
                            cs_n    <= 1'b0;
                            mosi    <= w_hdr[HDR_MAX-1];
                            r_tx    <= w_hdr;
                            r_cnt   <= length;
                            r_bit   <= '0;
                            r_pend  <= 1'b0;
                            r_last  <= 1'b0;
                            r_abort <= 1'b0;
                        end
                    end
                end

                ST_CMD, ST_ADDR, ST_DUMMY: begin
                    if (w_rise) begin
                        sck   <= 1'b1;
                        r_bit <= r_bit + 6'd1;
                        if (r_state == ST_CMD && r_bit == 6'd7) begin
                            r_state <= ST_ADDR;
                            r_bit   <= '0;
                        end else if (r_state == ST_ADDR && r_bit == 6'd23) begin
`ifdef SPI_FLASH_FAST_READ_EN
                            r_state <= ST_DUMMY;
`else
                            r_state <= ST_DATA;
`endif
                            r_bit   <= '0;
                        end else if (r_state == ST_DUMMY && r_bit == 6'd7) begin
                            r_state <= ST_DATA;
                            r_bit   <= '0;
                        end
                    end
                    if (w_fall) begin
                        sck  <= 1'b0;
                        r_tx <= r_tx << 1;
                        mosi <= r_tx[HDR_MAX-2];
                    end
                end

                ST_DATA: begin
                    if (w_rise) begin
                        sck     <= 1'b1;
                        r_shift <= {r_shift[6:0], miso};
                        if (r_bit[2:0] == 3'd7) begin
                            r_bit  <= '0;
                            r_pend <= 1'b1;
                            r_cnt  <= r_cnt - LEN_W'(1);
                            if (r_cnt == LEN_W'(1)) begin
                                r_last <= 1'b1;
                            end
                        end else begin
                            r_bit <= r_bit + 6'd1;
                        end
                    end
                    // Decide on the trailing fall: finish, stall, or keep clocking
                    if (w_fall) begin
                        sck  <= 1'b0;
                        mosi <= 1'b0;
                        if (r_last) begin
                            cs_n    <= 1'b1;
                            r_gap   <= '0;
                            r_state <= ST_FINISH;
                        end else if (r_pend && !w_free) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (w_move) begin
                        r_state <= ST_DATA;
                    end
                end

                ST_FINISH: begin
                    if (32'(r_gap) < CS_GAP) begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                    if ((32'(r_gap) + 32'd1 >= CS_GAP) && !r_pend && !out_valid) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= !r_abort;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Abort overrides everything above outside IDLE
            if (abort && r_state != ST_IDLE) begin
                r_state   <= ST_FINISH;
                r_abort   <= 1'b1;
                r_pend    <= 1'b0;
                r_gap     <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                cs_n      <= 1'b1;
                sck       <= 1'b0;
                mosi      <= 1'b0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
